branch_resolve_ctrl: RTL

BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

---
 rtl/branch_ctrl_pkg.sv | 36 +++
 rtl/branch_ctrl_fifo.sv | 71 +++++++
 rtl/branch_resolve_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared types and defaults for the branch resolve controller: queue entry,
// FSM state encoding and the saturating counter helper.
package branch_ctrl_pkg;

    localparam int BR_DEPTH_DEF  = 4;
    localparam int BR_ADDR_W_DEF = 32;

    typedef struct packed {
        logic                     taken;
        logic [BR_ADDR_W_DEF-1:0] target;
        logic [BR_ADDR_W_DEF-1:0] fallthru;
    } br_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_TRACK = 2'd1,
        ST_FLUSH = 2'd2
    } br_state_e;

    localparam br_entry_t BR_ENTRY_ZERO = '{
        taken:    1'b0,
        target:   {BR_ADDR_W_DEF{1'b0}},
        fallthru: {BR_ADDR_W_DEF{1'b0}}
    };

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_ctrl_fifo.sv
// In-flight branch queue: entry storage plus head/tail pointers carrying one
// extra wrap bit so a full queue is distinguishable from an empty one.
module branch_ctrl_fifo
    import branch_ctrl_pkg::*;
#(
    parameter int  DEPTH = BR_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clr_i,
    input  br_entry_t     push_entry_i,
    output br_entry_t     head_entry_o,
    output logic [CW-1:0] count_o,
    output logic          full_o
);

    br_entry_t   mem_q [DEPTH];
    br_entry_t   mem_d [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;

    // Next-state for storage and pointers; clear wins over a same-cycle push or pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = {(AW+1){1'b0}};
            rd_ptr_d = {(AW+1){1'b0}};
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_entry_i;
                wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= BR_ENTRY_ZERO;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    assign head_entry_o = mem_q[rd_ptr_q[AW-1:0]];
    assign count_o      = wr_ptr_q - rd_ptr_q;
    assign full_o       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: queues decode-stage predictions, checks them at
// resolve and raises flush/redirect and predictor updates. Optional
// resolve/mispredict statistics are enabled with the BRANCH_STATS_EN macro.
module branch_resolve_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int DEPTH  = BR_DEPTH_DEF,
    parameter int ADDR_W = BR_ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pred_valid,
    input  logic                     pred_taken,
    input  logic [ADDR_W-1:0]        pred_target,
    input  logic [ADDR_W-1:0]        pred_fallthru,
    output logic                     pred_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     flush,
    output logic [ADDR_W-1:0]        redirect_pc,
    output logic                     upd_valid,
    output logic                     upd_taken,
    output logic [$clog2(DEPTH):0]   inflight,
    output logic                     err_underflow
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]              stat_resolved,
    output logic [31:0]              stat_mispred
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    br_state_e         state_q;
    br_state_e         state_d;
    logic              flush_q;
    logic              flush_d;
    logic [ADDR_W-1:0] redirect_pc_q;
    logic [ADDR_W-1:0] redirect_pc_d;
    logic              upd_valid_q;
    logic              upd_valid_d;
    logic              upd_taken_q;
    logic              upd_taken_d;
    logic              err_underflow_q;
    logic              err_underflow_d;

    logic              push_s;
    logic              pop_s;
    logic              resolve_s;
    logic              mispred_s;
    logic              underflow_s;
    logic              full_s;
    logic [CW-1:0]     count_s;
    logic [CW-1:0]     count_next_s;
    br_entry_t         push_entry_s;
    br_entry_t         head_s;

    branch_ctrl_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push_s),
        .pop_i        (pop_s),
        .clr_i        (mispred_s),
        .push_entry_i (push_entry_s),
        .head_entry_o (head_s),
        .count_o      (count_s),
        .full_o       (full_s)
    );

`ifdef BRANCH_STATS_EN
    // Decode is held off while reset is clearing the statistics counters.
    assign pred_ready = rst_n && !full_s && (state_q != ST_FLUSH);
`else
    assign pred_ready = !full_s && (state_q != ST_FLUSH);
`endif

    // Handshake decode, resolve compare and next occupancy.
    always_comb begin
        push_entry_s          = BR_ENTRY_ZERO;
        push_entry_s.taken    = pred_taken;
        push_entry_s.target   = BR_ADDR_W_DEF'(pred_target);
        push_entry_s.fallthru = BR_ADDR_W_DEF'(pred_fallthru);
        push_s       = pred_valid && pred_ready;
        resolve_s    = res_valid && (count_s != {CW{1'b0}}) && (state_q != ST_FLUSH);
        underflow_s  = res_valid && (count_s == {CW{1'b0}}) && (state_q != ST_FLUSH);
        mispred_s    = resolve_s && (res_taken != head_s.taken);
        pop_s        = resolve_s && !mispred_s;
        count_next_s = count_s + CW'(push_s) - CW'(pop_s);
    end

    // FSM next state; a mispredict overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (mispred_s) begin
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_EMPTY: state_d = push_s ? ST_TRACK : ST_EMPTY;
                ST_TRACK: state_d = (count_next_s == {CW{1'b0}}) ? ST_EMPTY : ST_TRACK;
                ST_FLUSH: state_d = ST_EMPTY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Output pulses and the redirect target, which holds between flushes.
    always_comb begin
        flush_d         = mispred_s;
        upd_valid_d     = resolve_s;
        err_underflow_d = err_underflow_q || underflow_s;
        if (resolve_s) begin
            upd_taken_d = res_taken;
        end else begin
            upd_taken_d = 1'b0;
        end
        if (mispred_s) begin
            redirect_pc_d = res_taken ? ADDR_W'(head_s.target) : ADDR_W'(head_s.fallthru);
        end else begin
            redirect_pc_d = redirect_pc_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_EMPTY;
            flush_q         <= 1'b0;
            redirect_pc_q   <= {ADDR_W{1'b0}};
            upd_valid_q     <= 1'b0;
            upd_taken_q     <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_q         <= flush_d;
            redirect_pc_q   <= redirect_pc_d;
            upd_valid_q     <= upd_valid_d;
            upd_taken_q     <= upd_taken_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign flush         = flush_q;
    assign redirect_pc   = redirect_pc_q;
    assign upd_valid     = upd_valid_q;
    assign upd_taken     = upd_taken_q;
    assign inflight      = count_s;
    assign err_underflow = err_underflow_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_resolved_q;
    logic [31:0] stat_resolved_d;
    logic [31:0] stat_mispred_q;
    logic [31:0] stat_mispred_d;

    // Saturating resolve and mispredict counters.
    always_comb begin
        if (resolve_s) begin
            stat_resolved_d = sat_inc32(stat_resolved_q);
        end else begin
            stat_resolved_d = stat_resolved_q;
        end
        if (mispred_s) begin
            stat_mispred_d = sat_inc32(stat_mispred_q);
        end else begin
            stat_mispred_d = stat_mispred_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved_q <= 32'd0;
            stat_mispred_q  <= 32'd0;
        end else begin
            stat_resolved_q <= stat_resolved_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_resolved = stat_resolved_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule
